pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 10, width of the program counter and target bus.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address entries; legal range 1..16.
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 PC_en  input  1  update strobe; op is executed only in cycles where PC_en=1.
REQ-007 op  input  3  operation: 000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101-111 HOLD.
REQ-008 cond  input  1  branch condition; used only by BRANCH.
REQ-009 target  input  PC_WIDTH  absolute address for JUMP/CALL; two's-complement offset for BRANCH.
REQ-010 PC_output  output  PC_WIDTH  registered current program counter.
REQ-011 depth  output  clog2(STACK_DEPTH+1)  registered count of valid stack entries.
REQ-012 overflow  output  1  sticky; set by CALL on a full stack.
REQ-013 underflow  output  1  sticky; set by RET on an empty stack.

Function
REQ-014 PC_output, depth, overflow and underflow shall change only on rising clock edges; latency from PC_en sample to new PC_output is one cycle.
REQ-015 PC_en=0 shall hold all state, whatever op, cond and target are.
REQ-016 INC: PC <= PC+1 modulo 2^PC_WIDTH; all-ones wraps to 0.
REQ-017 JUMP: PC <= target.
REQ-018 BRANCH: cond=1 -> PC <= PC + sign-extended target modulo 2^PC_WIDTH; cond=0 -> PC <= PC+1.
REQ-019 CALL, stack not full: push PC+1 (wrapped), depth+1, PC <= target.
REQ-020 CALL, stack full (depth=STACK_DEPTH): overflow <= 1; stack, depth and PC unchanged.
REQ-021 RET, stack not empty: PC <= top entry, pop, depth-1.
REQ-022 RET, stack empty: underflow <= 1; PC and depth unchanged.
REQ-023 HOLD (101-111): PC and stack unchanged; no flag change.
REQ-024 Fault state: when overflow or underflow is 1, the block shall ignore PC_en and hold all state until reset.
REQ-025 Stack shall be strictly LIFO; a push to depth STACK_DEPTH-1 and then a pop shall return the most recent push.
REQ-026 Only one op executes per cycle; no simultaneous push and pop exists by construction.

Reset
REQ-027 reset=1 at a rising edge: PC_output <= RESET_VECTOR, depth <= 0, overflow <= 0, underflow <= 0.
REQ-028 reset shall take priority over PC_en and any op in the same cycle, including mid-CALL/RET sequences and the fault state.
REQ-029 Stack storage contents need not be cleared; depth=0 makes them invalid.

Structure
REQ-030 Opcode constants (OP_INC, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET) shall live in a shared definitions file pc_defs used by the sequencer and the future decoder.
REQ-031 The return stack shall be a sub-module lifo_stack (params WIDTH, DEPTH; ports clock, reset, push, pop, din, dout, depth, full, empty).
REQ-032 pc_sequencer shall hold only the PC register, next-PC mux, fault flags and the lifo_stack instance.

Verification (PC_WIDTH=10, STACK_DEPTH=4, RESET_VECTOR=0)
REQ-033 Reset held 2 cycles then PC_en=1, op=INC for 5 cycles -> PC_output 0,1,2,3,4,5; depth=0.
REQ-034 PC=1023, INC -> PC=0; PC=5, BRANCH target=10'h3FE (-2), cond=1 -> PC=3; cond=0 -> PC=6.
REQ-035 PC=0x010, CALL 0x100, CALL 0x200, RET, RET -> PC 0x100, 0x200, 0x101, 0x011; depth 1,2,1,0.
REQ-036 Five CALLs from PC=0 to targets 0x10,0x20,0x30,0x40,0x50 -> after fourth depth=4, PC=0x40; fifth sets overflow=1, PC stays 0x40; subsequent INC ignored.
REQ-037 After reset, RET -> underflow=1, PC=0; assert reset one cycle -> underflow=0, PC=0, INC resumes.
REQ-038 PC_en=0 with op cycling through all codes for 8 cycles -> PC, depth, flags constant.

Source files
------------

// File: rtl/pc_defs.sv
// Shared opcode definitions for the program-counter sequencer and the instruction decoder.
// Codes 101-111 have no named member; they act as HOLD.
package pc_defs;

    typedef enum logic [2:0] {
        OP_INC    = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100
    } op_e;

    localparam int OP_WIDTH = 3;

endpackage

// File: rtl/pc_sequencer_lifo_stack.sv
// Return-address LIFO: registered depth count, with the top entry presented combinationally on dout.
// Storage is never cleared, because the depth count alone decides which entries are valid.
module lifo_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_depth;
    logic [AW-1:0]    w_wrIdx;
    logic [AW-1:0]    w_topIdx;

    assign full     = (r_depth == DW'(DEPTH));
    assign empty    = (r_depth == '0);
    assign w_wrIdx  = AW'(r_depth);
    assign w_topIdx = AW'(r_depth - DW'(1));
    assign dout     = empty ? '0 : r_mem[w_topIdx];
    assign depth    = r_depth;

    // Push wins over pop if both are ever raised; the sequencer never does that.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_depth <= '0;
        end else if (push && !full) begin
            r_mem[w_wrIdx] <= din;
            r_depth        <= r_depth + DW'(1);
        end else if (pop && !empty) begin
            r_depth <= r_depth - DW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC selection, sticky stack fault flags and return stack.
// Once either fault flag is set, only reset can bring the block back.
module pc_sequencer
    import pc_defs::*;
#(
    parameter int PC_WIDTH     = 10,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_VECTOR = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               PC_en,
    input  logic [OP_WIDTH-1:0]                op,
    input  logic                               cond,
    input  logic [PC_WIDTH-1:0]                target,
    output logic [PC_WIDTH-1:0]                PC_output,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               overflow,
    output logic                               underflow
);

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_overflow;
    logic                r_underflow;

    logic [PC_WIDTH-1:0] w_nextPc;
    logic [PC_WIDTH-1:0] w_pcPlusOne;
    logic [PC_WIDTH-1:0] w_stackTop;
    logic                w_active;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_setOverflow;
    logic                w_setUnderflow;

    assign w_active    = PC_en && !r_overflow && !r_underflow;
    assign w_pcPlusOne = r_pc + PC_WIDTH'(1);

    // Target is already PC_WIDTH wide, so a plain add gives the sign-extended branch modulo 2^PC_WIDTH.
    always_comb begin
        w_nextPc       = r_pc;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_setOverflow  = 1'b0;
        w_setUnderflow = 1'b0;
        if (w_active) begin
            case (op)
                OP_INC:    w_nextPc = w_pcPlusOne;
                OP_JUMP:   w_nextPc = target;
                OP_BRANCH: w_nextPc = cond ? (r_pc + target) : w_pcPlusOne;
                OP_CALL: begin
                    if (w_full) begin
                        w_setOverflow = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_nextPc = target;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_setUnderflow = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_nextPc = w_stackTop;
                    end
                end
                default: w_nextPc = r_pc;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= PC_WIDTH'(RESET_VECTOR);
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc <= w_nextPc;
            if (w_setOverflow)
                r_overflow <= 1'b1;
            if (w_setUnderflow)
                r_underflow <= 1'b1;
        end
    end

    lifo_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pcPlusOne),
        .dout  (w_stackTop),
        .depth (depth),
        .full  (w_full),
        .empty (w_empty)
    );

    assign PC_output = r_pc;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-and-integer reference model predicts each post-edge state,
// and an independent monitor compares it against the DUT one time unit after every rising edge.
module tb_pc_sequencer;
    import pc_defs::*;

    localparam int PW    = 10;
    localparam int SD    = 4;
    localparam int DW    = 3;
    localparam int PCMOD = 1 << PW;

    logic          clock = 1'b0;
    logic          reset;
    logic          PC_en;
    logic [2:0]    op;
    logic          cond;
    logic [PW-1:0] target;
    logic [PW-1:0] PC_output;
    logic [DW-1:0] depth;
    logic          overflow;
    logic          underflow;

    typedef struct {
        int pc;
        int depth;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb[$];
    exp_t monEntry;
    int   errors = 0;
    int   checks = 0;

    int   mPc = 0;
    int   mStack[$];
    bit   mOvf = 1'b0;
    bit   mUnf = 1'b0;

    pc_sequencer #(
        .PC_WIDTH     (PW),
        .STACK_DEPTH  (SD),
        .RESET_VECTOR (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .PC_en     (PC_en),
        .op        (op),
        .cond      (cond),
        .target    (target),
        .PC_output (PC_output),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour: PC as an integer modulo 2^PW, return stack as a queue.
    function automatic void modelStep(input bit rst, input bit en, input int o, input bit c, input int t);
        int off;
        if (rst) begin
            mPc = 0;
            mStack.delete();
            mOvf = 1'b0;
            mUnf = 1'b0;
        end else if (en && !mOvf && !mUnf) begin
            case (o)
                0: mPc = (mPc + 1) % PCMOD;
                1: mPc = t;
                2: begin
                    if (c) begin
                        off = (t >= PCMOD / 2) ? t - PCMOD : t;
                        mPc = ((mPc + off) % PCMOD + PCMOD) % PCMOD;
                    end else begin
                        mPc = (mPc + 1) % PCMOD;
                    end
                end
                3: begin
                    if (mStack.size() == SD) begin
                        mOvf = 1'b1;
                    end else begin
                        mStack.push_back((mPc + 1) % PCMOD);
                        mPc = t;
                    end
                end
                4: begin
                    if (mStack.size() == 0)
                        mUnf = 1'b1;
                    else
                        mPc = mStack.pop_back();
                end
                default: ;
            endcase
        end
    endfunction

    // Drive one cycle on the falling edge, queue the predicted state, return just after the rising edge.
    task automatic applyStimulus(input bit rst, input bit en, input int o, input bit c, input int t);
        exp_t e;
        @(negedge clock);
        reset  = rst;
        PC_en  = en;
        op     = 3'(o);
        cond   = c;
        target = PW'(t);
        modelStep(rst, en, o, c, t);
        e.pc    = mPc;
        e.depth = mStack.size();
        e.ovf   = mOvf;
        e.unf   = mUnf;
        sb.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic expectState(input string name, input int pc, input int d, input bit ovf, input bit unf);
        checkOutput({name, ".pc"}, int'(PC_output), pc);
        checkOutput({name, ".depth"}, int'(depth), d);
        checkOutput({name, ".ovf"}, int'(overflow), int'(ovf));
        checkOutput({name, ".unf"}, int'(underflow), int'(unf));
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                monEntry = sb.pop_front();
                checkOutput("sb.PC_output", int'(PC_output), monEntry.pc);
                checkOutput("sb.depth", int'(depth), monEntry.depth);
                checkOutput("sb.overflow", int'(overflow), int'(monEntry.ovf));
                checkOutput("sb.underflow", int'(underflow), int'(monEntry.unf));
            end
        end
    end

    initial begin
        int r;
        int o;
        reset  = 1'b1;
        PC_en  = 1'b0;
        op     = '0;
        cond   = 1'b0;
        target = '0;

        // Reset then five increments.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        expectState("reset", 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("inc.pc", int'(PC_output), i);
        end
        checkOutput("inc.depth", int'(depth), 0);

        // Wrap and branch boundaries.
        applyStimulus(0, 1, 1, 0, 10'h3FF);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap.pc", int'(PC_output), 0);
        applyStimulus(0, 1, 1, 0, 5);
        applyStimulus(0, 1, 2, 1, 10'h3FE);
        checkOutput("branchTaken.pc", int'(PC_output), 3);
        applyStimulus(0, 1, 1, 0, 5);
        applyStimulus(0, 1, 2, 0, 10'h3FE);
        checkOutput("branchNotTaken.pc", int'(PC_output), 6);

        // Nested call/return.
        applyStimulus(0, 1, 1, 0, 10'h010);
        applyStimulus(0, 1, 3, 0, 10'h100);
        expectState("call1", 10'h100, 1, 0, 0);
        applyStimulus(0, 1, 3, 0, 10'h200);
        expectState("call2", 10'h200, 2, 0, 0);
        applyStimulus(0, 1, 4, 0, 0);
        expectState("ret1", 10'h101, 1, 0, 0);
        applyStimulus(0, 1, 4, 0, 0);
        expectState("ret2", 10'h011, 0, 0, 0);

        // Overflow on the fifth call, then fault hold.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            applyStimulus(0, 1, 3, 0, i * 16);
        expectState("overflow", 10'h040, 4, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        expectState("faultHold", 10'h040, 4, 1, 0);

        // Underflow from empty, reset wins over a CALL in the same cycle, then resume.
        applyStimulus(1, 1, 3, 0, 10'h2AA);
        expectState("resetPriority", 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 0);
        expectState("underflow", 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        expectState("underflowClear", 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("resume.pc", int'(PC_output), 1);

        // Disabled cycles with every opcode.
        applyStimulus(0, 1, 1, 0, 10'h123);
        applyStimulus(0, 1, 3, 0, 10'h055);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 0, i, $urandom_range(0, 1), $urandom_range(0, PCMOD - 1));
        expectState("enableLow", 10'h055, 1, 0, 0);

        // Random traffic biased towards stack operations, with occasional reset.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       o = 0;
            else if (r == 2) o = 1;
            else if (r == 3) o = 2;
            else if (r < 6)  o = 3;
            else if (r < 8)  o = 4;
            else             o = $urandom_range(5, 7);
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, o,
                          $urandom_range(0, 1), $urandom_range(0, PCMOD - 1));
        end

        @(negedge clock);
        PC_en = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("scoreboardDrained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
